feedback_stim_encoder: RTL and testbench
========================================

FEEDBACK_STIM_ENCODER -- requirements
Module: feedback_stim_encoder

Interface
REQ-001 SHALL have parameter BOARD_HEIGHT, default 16, ball_y range; power of two.
REQ-002 SHALL have parameter NUM_CH, default 8, stimulation channel count; power of two, ≤ BOARD_HEIGHT.
REQ-003 SHALL have parameter SENSE_BASE, default 100, base sensory interval in cycles (≥2).
REQ-004 SHALL have parameter SENSE_SHIFT, default 2, ball_x weighting shift for the interval.
REQ-005 SHALL have parameters WIN_PULSES, default 4, and WIN_GAP, default 10: the win burst pulse count and the gap in cycles after each pulse.
REQ-006 SHALL have parameters LOSE_PULSES, default 16, and LOSE_GAP, default 5: the lose burst pulse count and the gap in cycles after each pulse.
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1, the non-zero noise generator seed.
REQ-008 clk  input  1  single clock; all logic on its rising edge.
REQ-009 reset_n  input  1  reset, synchronous, active-low.
REQ-010 enable  input  1  encoder enable.
REQ-011 ball_x  input  8  ball x position from the game stage.
REQ-012 ball_y  input  8  ball y position from the game stage.
REQ-013 result_en  input  1  level, high while the game stage is in its round-end state.
REQ-014 game_result  input  1  1 = win, 0 = lose; valid while result_en is high.
REQ-015 stim_valid  output  1  stimulation request valid.
REQ-016 stim_ready  input  1  downstream stimulator accepts the request.
REQ-017 stim_channel  output  log2(NUM_CH)  target electrode channel.
REQ-018 stim_kind  output  2  request class: 00 sensory, 01 win, 10 lose.
REQ-019 feedback_active  output  1  high in WIN_BURST or LOSE_NOISE.
REQ-020 pulse_count  output  16  accepted requests; saturates at 16'hFFFF.

Function
REQ-021 SHALL implement states IDLE, SENSE, WIN_BURST, LOSE_NOISE.
REQ-022 A request is accepted in a cycle with stim_valid=1 and stim_ready=1.
REQ-023 While stim_valid=1 and stim_ready=0, stim_valid, stim_channel and stim_kind SHALL hold stable.
REQ-024 Channel map: ch = min(ball_y*NUM_CH/BOARD_HEIGHT, NUM_CH-1), using unsigned integer arithmetic; with default parameters ch = ball_y>>1, and ball_y≥16 gives 7.
REQ-025 Sensory period: P = SENSE_BASE + (ball_x<<SENSE_SHIFT), computed at 16 bits and sampled on each acceptance.
REQ-026 SENSE state, interval counter:
- decrements only while stim_valid=0;
- at 0, raises stim_valid with kind 00 and the channel from the current ball_y;
- on acceptance, reloads to P-1.
- With stim_ready=1 held, consecutive sensory requests are exactly P cycles apart.
REQ-027 Feedback trigger: SHALL detect the rising edge of result_en by comparing against a registered copy, and SHALL capture game_result and the mapped channel on that edge.
REQ-028 Trigger timing:
- in IDLE, ignored;
- in SENSE, the target state is entered after any pending sensory request is accepted;
- in WIN_BURST or LOSE_NOISE, ignored.
- The pending trigger is not lost.
REQ-029 WIN_BURST: SHALL issue WIN_PULSES requests, kind 01, on the captured channel, with WIN_GAP idle cycles after each acceptance.
REQ-030 LOSE_NOISE: SHALL issue LOSE_PULSES requests, kind 10, with channel = lfsr[log2(NUM_CH)-1:0], and LOSE_GAP idle cycles after each acceptance.
- The LFSR is a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1.
- It advances once per lose acceptance only.
REQ-031 After the last burst acceptance, the block SHALL return to SENSE with the interval counter loaded to P-1; if enable=0, it SHALL go to IDLE instead.
REQ-032 Leaving IDLE: IDLE→SENSE when enable=1, with the counter loaded to SENSE_BASE-1.
REQ-033 enable falling: a pending request completes; then the block goes to IDLE; an in-progress burst completes first.
REQ-034 Burst counters and gap counters SHALL be sized from their parameters and SHALL not wrap.

Reset
REQ-035 On reset_n=0 at a clock edge, the following values SHALL be loaded:
- state IDLE;
- stim_valid 0, stim_channel 0, stim_kind 00;
- feedback_active 0, pulse_count 0;
- lfsr LFSR_SEED;
- result_en register 0;
- interval counter SENSE_BASE-1.
REQ-036 Reset asserted mid-burst or mid-handshake SHALL abort it with no further requests.

Verification
REQ-037 Sensory spacing: enable=1, ball_x=0, ball_y=5, stim_ready=1 → kind 00, channel 2, requests exactly 100 cycles apart.
REQ-038 Interval scaling and clamp: ball_x=10 → spacing 140 cycles; ball_y=20 → channel 7.
REQ-039 Win burst: result_en rises with game_result=1 and ball_y=9 → 4 requests, kind 01, channel 4, 11 cycles apart; feedback_active high throughout; then sensory resumes.
REQ-040 Lose burst: result_en rises with game_result=0 → 16 requests, kind 10; channels follow the LFSR sequence from 16'hACE1; pulse_count +16.
REQ-041 Backpressure: stim_ready=0 for 50 cycles while a sensory request is pending, with result_en rising meanwhile → outputs stable; the burst starts only after acceptance.
REQ-042 Reset mid-burst: reset_n=0 during LOSE_NOISE → next cycle stim_valid=0, pulse_count=0, and the LFSR is reseeded.

Source files
------------

// File: rtl/feedback_stim_encoder_if.sv
// Stimulation request handshake between the feedback encoder (master)
// and the downstream stimulator (slave).
interface feedback_stim_encoder_if #(
  parameter int unsigned CH_W = 3
);
  logic            stim_valid;
  logic            stim_ready;
  logic [CH_W-1:0] stim_channel;
  logic [1:0]      stim_kind;

  modport master (output stim_valid, output stim_channel, output stim_kind, input stim_ready);
  modport slave  (input stim_valid, input stim_channel, input stim_kind, output stim_ready);
endinterface

// File: rtl/feedback_stim_encoder.sv
// Converts game-stage ball position and round results into stimulation
// requests: periodic sensory pulses, a fixed win burst and a noisy lose burst.
module feedback_stim_encoder #(
  parameter int unsigned BOARD_HEIGHT = 16,
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned SENSE_BASE   = 100,
  parameter int unsigned SENSE_SHIFT  = 2,
  parameter int unsigned WIN_PULSES   = 4,
  parameter int unsigned WIN_GAP      = 10,
  parameter int unsigned LOSE_PULSES  = 16,
  parameter int unsigned LOSE_GAP     = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [7:0]              ball_x,
  input  logic [7:0]              ball_y,
  input  logic                    result_en,
  input  logic                    game_result,
  feedback_stim_encoder_if.master stim,
  output logic                    feedback_active,
  output logic [15:0]             pulse_count
);

  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_PULSES = (WIN_PULSES > LOSE_PULSES) ? WIN_PULSES : LOSE_PULSES;
  localparam int unsigned MAX_GAP    = (WIN_GAP > LOSE_GAP) ? WIN_GAP : LOSE_GAP;
  localparam int unsigned BURST_W    = (MAX_PULSES > 1) ? $clog2(MAX_PULSES) : 1;
  localparam int unsigned GAP_W      = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

  localparam logic [15:0] SENSE_RELOAD = 16'(SENSE_BASE - 1);
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [1:0]  KIND_SENSE   = 2'b00;
  localparam logic [1:0]  KIND_WIN     = 2'b01;
  localparam logic [1:0]  KIND_LOSE    = 2'b10;

  typedef enum logic [1:0] {IDLE, SENSE, WIN_BURST, LOSE_NOISE} state_t;

  state_t             state, state_n;
  logic               valid_q, valid_n;
  logic [CH_W-1:0]    ch_q, ch_n;
  logic [1:0]         kind_q, kind_n;
  logic [15:0]        cnt_q, cnt_n;
  logic [BURST_W-1:0] burst_q, burst_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [15:0]        lfsr_q, lfsr_n;
  logic               pend_q, pend_n;
  logic               pend_win_q, pend_win_n;
  logic [CH_W-1:0]    pend_ch_q, pend_ch_n;
  logic               result_en_q;
  logic [15:0]        pulse_n;

  logic               accept;
  logic               rise;
  logic               go_burst;
  logic               is_lose;
  logic [15:0]        period;
  logic [15:0]        reload;
  logic [15:0]        lfsr_step;
  logic [CH_W-1:0]    y_ch;
  logic [BURST_W-1:0] last_idx;
  logic [GAP_W-1:0]   gap_len;

  // Row-to-electrode mapping, clamped for ball_y beyond the board.
  function automatic logic [CH_W-1:0] map_ch(input logic [7:0] y);
    logic [31:0] scaled;
    scaled = (32'(y) * 32'(NUM_CH)) / 32'(BOARD_HEIGHT);
    if (scaled > 32'(NUM_CH - 1)) map_ch = CH_W'(NUM_CH - 1);
    else                          map_ch = CH_W'(scaled);
  endfunction

  assign accept    = valid_q & stim.stim_ready;
  assign rise      = result_en & ~result_en_q;
  assign period    = 16'(SENSE_BASE) + ({8'd0, ball_x} << SENSE_SHIFT);
  assign reload    = period - 16'd1;
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign y_ch      = map_ch(ball_y);
  assign is_lose   = (state == LOSE_NOISE);
  assign last_idx  = is_lose ? BURST_W'(LOSE_PULSES - 1) : BURST_W'(WIN_PULSES - 1);
  assign gap_len   = is_lose ? GAP_W'(LOSE_GAP) : GAP_W'(WIN_GAP);

  assign stim.stim_valid   = valid_q;
  assign stim.stim_channel = ch_q;
  assign stim.stim_kind    = kind_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      valid_q         <= 1'b0;
      ch_q            <= '0;
      kind_q          <= KIND_SENSE;
      cnt_q           <= SENSE_RELOAD;
      burst_q         <= '0;
      gap_q           <= '0;
      lfsr_q          <= LFSR_SEED;
      pend_q          <= 1'b0;
      pend_win_q      <= 1'b0;
      pend_ch_q       <= '0;
      result_en_q     <= 1'b0;
      feedback_active <= 1'b0;
      pulse_count     <= '0;
    end else begin
      state           <= state_n;
      valid_q         <= valid_n;
      ch_q            <= ch_n;
      kind_q          <= kind_n;
      cnt_q           <= cnt_n;
      burst_q         <= burst_n;
      gap_q           <= gap_n;
      lfsr_q          <= lfsr_n;
      pend_q          <= pend_n;
      pend_win_q      <= pend_win_n;
      pend_ch_q       <= pend_ch_n;
      result_en_q     <= result_en;
      feedback_active <= (state_n == WIN_BURST) || (state_n == LOSE_NOISE);
      pulse_count     <= pulse_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    valid_n    = valid_q;
    ch_n       = ch_q;
    kind_n     = kind_q;
    cnt_n      = cnt_q;
    burst_n    = burst_q;
    gap_n      = gap_q;
    lfsr_n     = lfsr_q;
    pend_n     = pend_q;
    pend_win_n = pend_win_q;
    pend_ch_n  = pend_ch_q;
    go_burst   = 1'b0;
    pulse_n    = (accept && (pulse_count != 16'hFFFF)) ? pulse_count + 16'd1 : pulse_count;

    case (state)
      IDLE: begin
        valid_n = 1'b0;
        pend_n  = 1'b0;
        if (enable) begin
          state_n = SENSE;
          cnt_n   = SENSE_RELOAD;
        end
      end

      SENSE: begin
        if (rise && !pend_q) begin
          pend_n     = 1'b1;
          pend_win_n = game_result;
          pend_ch_n  = y_ch;
        end
        // Counter only runs with no request outstanding; reaching zero raises one.
        if (valid_q) begin
          if (accept) begin
            valid_n = 1'b0;
            cnt_n   = reload;
            if (pend_q)       go_burst = 1'b1;
            else if (!enable) state_n  = IDLE;
          end
        end else if (pend_q) begin
          go_burst = 1'b1;
        end else if (!enable) begin
          state_n = IDLE;
        end else if (cnt_q <= 16'd1) begin
          valid_n = 1'b1;
          kind_n  = KIND_SENSE;
          ch_n    = y_ch;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end

        if (go_burst) begin
          pend_n  = 1'b0;
          burst_n = '0;
          gap_n   = '0;
          valid_n = 1'b1;
          if (pend_win_q) begin
            state_n = WIN_BURST;
            kind_n  = KIND_WIN;
            ch_n    = pend_ch_q;
          end else begin
            state_n = LOSE_NOISE;
            kind_n  = KIND_LOSE;
            ch_n    = lfsr_q[CH_W-1:0];
          end
        end
      end

      WIN_BURST, LOSE_NOISE: begin
        if (valid_q) begin
          if (accept) begin
            if (is_lose) lfsr_n = lfsr_step;
            if (burst_q == last_idx) begin
              valid_n = 1'b0;
              if (enable) begin
                state_n = SENSE;
                cnt_n   = reload;
              end else begin
                state_n = IDLE;
              end
            end else begin
              burst_n = burst_q + BURST_W'(1);
              if (gap_len == '0) begin
                if (is_lose) ch_n = lfsr_step[CH_W-1:0];
              end else begin
                valid_n = 1'b0;
                gap_n   = gap_len;
              end
            end
          end
        end else if (gap_q <= GAP_W'(1)) begin
          valid_n = 1'b1;
          gap_n   = '0;
          if (is_lose) ch_n = lfsr_q[CH_W-1:0];
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_feedback_stim_encoder.sv
// Directed self-checking bench for feedback_stim_encoder with default parameters.
module tb_feedback_stim_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ball_x;
  logic [7:0]  ball_y;
  logic        result_en;
  logic        game_result;
  logic        feedback_active;
  logic [15:0] pulse_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Low three bits of the Galois LFSR states starting from 16'hACE1.
  logic [2:0] lose_ch [16] = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd3, 3'd1,
                               3'd4, 3'd2, 3'd1, 3'd0, 3'd4, 3'd6, 3'd3, 3'd5};

  feedback_stim_encoder_if #(.CH_W(3)) sif ();

  feedback_stim_encoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .result_en       (result_en),
    .game_result     (game_result),
    .stim            (sif),
    .feedback_active (feedback_active),
    .pulse_count     (pulse_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Returns at the negedge where a request is about to be accepted.
  task automatic wait_accept(input int budget, output logic [1:0] kind, output logic [2:0] ch,
                             output int at, output logic fa);
    kind = 2'b11;
    ch   = 3'd0;
    at   = 0;
    fa   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sif.stim_valid === 1'b1 && sif.stim_ready === 1'b1) begin
        kind = sif.stim_kind;
        ch   = sif.stim_channel;
        at   = cyc;
        fa   = feedback_active;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_accept: no accepted request within %0d cycles", budget);
  endtask

  task automatic test_reset();
    int seen;
    reset_n = 1'b0; enable = 1'b0; ball_x = 8'd0; ball_y = 8'd0;
    result_en = 1'b0; game_result = 1'b0; sif.stim_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (sif.stim_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sif.stim_valid); end
    tests++; if (sif.stim_channel !== 3'd0) begin fails++; $display("FAIL reset_channel: got %0d want 0", sif.stim_channel); end
    tests++; if (sif.stim_kind !== 2'b00) begin fails++; $display("FAIL reset_kind: got %b want 00", sif.stim_kind); end
    tests++; if (feedback_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", feedback_active); end
    tests++; if (pulse_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", pulse_count); end
    reset_n = 1'b1;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (sif.stim_valid !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL idle_quiet: valid seen %0d cycles want 0", seen); end
  endtask

  task automatic test_sensory(output int last_at);
    logic [1:0] k; logic [2:0] c; logic fa; int t1, t2, t3;
    ball_x = 8'd0; ball_y = 8'd5; enable = 1'b1;
    wait_accept(300, k, c, t1, fa);
    tests++; if (k !== 2'b00) begin fails++; $display("FAIL sense_kind: got %b want 00", k); end
    tests++; if (c !== 3'd2) begin fails++; $display("FAIL sense_channel: got %0d want 2", c); end
    wait_accept(300, k, c, t2, fa);
    tests++; if (t2 - t1 !== 100) begin fails++; $display("FAIL sense_spacing1: got %0d want 100", t2 - t1); end
    wait_accept(300, k, c, t3, fa);
    tests++; if (t3 - t2 !== 100) begin fails++; $display("FAIL sense_spacing2: got %0d want 100", t3 - t2); end
    last_at = t3;
  endtask

  task automatic test_scaling(input int prev_at);
    logic [1:0] k; logic [2:0] c; logic fa; int t1, t2;
    ball_x = 8'd10; ball_y = 8'd20;
    wait_accept(400, k, c, t1, fa);
    tests++; if (t1 - prev_at !== 140) begin fails++; $display("FAIL scale_spacing1: got %0d want 140", t1 - prev_at); end
    tests++; if (c !== 3'd7 || k !== 2'b00) begin fails++; $display("FAIL clamp_channel: got ch %0d kind %b want ch 7 kind 00", c, k); end
    wait_accept(400, k, c, t2, fa);
    tests++; if (t2 - t1 !== 140) begin fails++; $display("FAIL scale_spacing2: got %0d want 140", t2 - t1); end
    tests++; if (pulse_count !== 16'd4) begin fails++; $display("FAIL count_sense: got %0d want 4", pulse_count); end
  endtask

  task automatic test_win_burst();
    logic [1:0] k; logic [2:0] c; logic fa; int t, prev;
    ball_x = 8'd0; ball_y = 8'd9; game_result = 1'b1; result_en = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(200, k, c, t, fa);
      result_en = 1'b0;
      tests++; if (k !== 2'b01 || c !== 3'd4 || fa !== 1'b1) begin
        fails++; $display("FAIL win_pulse%0d: got kind %b ch %0d active %b want kind 01 ch 4 active 1", i, k, c, fa);
      end
      if (i > 0) begin
        tests++; if (t - prev !== 11) begin fails++; $display("FAIL win_spacing%0d: got %0d want 11", i, t - prev); end
      end
      prev = t;
    end
    wait_accept(300, k, c, t, fa);
    tests++; if (k !== 2'b00 || c !== 3'd4 || fa !== 1'b0) begin
      fails++; $display("FAIL win_resume: got kind %b ch %0d active %b want kind 00 ch 4 active 0", k, c, fa);
    end
    tests++; if (t - prev !== 100) begin fails++; $display("FAIL win_resume_spacing: got %0d want 100", t - prev); end
    tests++; if (pulse_count !== 16'd9) begin fails++; $display("FAIL count_win: got %0d want 9", pulse_count); end
  endtask

  task automatic test_lose_burst();
    logic [1:0] k; logic [2:0] c; logic fa; int t, prev;
    game_result = 1'b0; result_en = 1'b1;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      wait_accept(200, k, c, t, fa);
      result_en = 1'b0;
      tests++; if (k !== 2'b10 || c !== lose_ch[i] || fa !== 1'b1) begin
        fails++; $display("FAIL lose_pulse%0d: got kind %b ch %0d active %b want kind 10 ch %0d active 1", i, k, c, fa, lose_ch[i]);
      end
      if (i > 0) begin
        tests++; if (t - prev !== 6) begin fails++; $display("FAIL lose_spacing%0d: got %0d want 6", i, t - prev); end
      end
      prev = t;
    end
    wait_accept(300, k, c, t, fa);
    tests++; if (k !== 2'b00 || fa !== 1'b0) begin fails++; $display("FAIL lose_resume: got kind %b active %b want kind 00 active 0", k, fa); end
    tests++; if (pulse_count !== 16'd26) begin fails++; $display("FAIL count_lose: got %0d want 26", pulse_count); end
  endtask

  task automatic test_backpressure();
    logic [1:0] k; logic [2:0] c; logic fa; int t, bad;
    sif.stim_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sif.stim_valid !== 1'b1 || sif.stim_kind !== 2'b00 || sif.stim_channel !== 3'd4 ||
          feedback_active !== 1'b0 || pulse_count !== 16'd26) bad++;
      if (i == 10) begin result_en = 1'b1; game_result = 1'b1; ball_y = 8'd2; end
      if (i == 20) result_en = 1'b0;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad); end
    sif.stim_ready = 1'b1;
    wait_accept(100, k, c, t, fa);
    tests++; if (k !== 2'b01 || c !== 3'd1) begin fails++; $display("FAIL bp_burst: got kind %b ch %0d want kind 01 ch 1", k, c); end
    tests++; if (pulse_count !== 16'd27) begin fails++; $display("FAIL bp_count: got %0d want 27", pulse_count); end
    for (int i = 0; i < 3; i++) begin
      wait_accept(100, k, c, t, fa);
      tests++; if (k !== 2'b01) begin fails++; $display("FAIL bp_drain%0d: got kind %b want 01", i, k); end
    end
    ball_y = 8'd9;
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] k; logic [2:0] c; logic fa; int t;
    wait_accept(300, k, c, t, fa);
    game_result = 1'b0; result_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(100, k, c, t, fa);
      result_en = 1'b0;
      tests++; if (k !== 2'b10) begin fails++; $display("FAIL pre_reset_kind%0d: got %b want 10", i, k); end
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests++; if (sif.stim_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", sif.stim_valid); end
    tests++; if (pulse_count !== 16'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", pulse_count); end
    tests++; if (feedback_active !== 1'b0) begin fails++; $display("FAIL midrst_active: got %b want 0", feedback_active); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_accept(300, k, c, t, fa);
    result_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(100, k, c, t, fa);
      result_en = 1'b0;
      tests++; if (k !== 2'b10 || c !== lose_ch[i]) begin
        fails++; $display("FAIL reseed%0d: got kind %b ch %0d want kind 10 ch %0d", i, k, c, lose_ch[i]);
      end
    end
  endtask

  task automatic test_disable();
    int lose_seen, other_seen;
    enable = 1'b0;
    lose_seen = 0; other_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (sif.stim_valid === 1'b1 && sif.stim_ready === 1'b1) begin
        if (sif.stim_kind === 2'b10) lose_seen++;
        else other_seen++;
      end
    end
    tests++; if (lose_seen !== 12) begin fails++; $display("FAIL disable_finish_burst: got %0d lose pulses want 12", lose_seen); end
    tests++; if (other_seen !== 0 || sif.stim_valid !== 1'b0) begin
      fails++; $display("FAIL disable_idle: got %0d other requests valid %b want 0 and 0", other_seen, sif.stim_valid);
    end
  endtask

  initial begin
    int last_at;
    test_reset();
    test_sensory(last_at);
    test_scaling(last_at);
    test_win_burst();
    test_lose_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
